// File: rtl/deconvolution.sv
// Recovers A from Y = A*B by sequential long division on a single MAC,
// then re-convolves the tail of Y to flag inputs that are not exact convolutions.
module deconvolution #(
    parameter int M  = 6,
    parameter int N  = 8,
    parameter int DW = 16,
    parameter int YW = 36,
    localparam int AW  = (M > 1) ? $clog2(M) : 1,
    localparam int BAW = (N > 1) ? $clog2(N) : 1,
    localparam int YAW = (M + N - 1 > 1) ? $clog2(M + N - 1) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           y_we,
    input  logic [YAW-1:0] y_addr,
    input  logic [YW-1:0]  y_data,
    input  logic           b_we,
    input  logic [BAW-1:0] b_addr,
    input  logic [DW-1:0]  b_data,
    input  logic           start,
    output logic           busy,
    output logic           done,
    input  logic [AW-1:0]  a_addr,
    output logic [DW-1:0]  a_data,
    output logic           err_div0,
    output logic           err_rem,
    output logic           err_ovf,
    output logic           err_resid
);

    localparam int ACW = YW + 2;
    localparam int KW  = $clog2(M + N) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_MAC, S_DIV, S_CINIT, S_CMAC, S_CCMP, S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [YW-1:0]  r_y [M+N-1];
    logic signed [DW-1:0]  r_b [N];
    logic signed [DW-1:0]  r_a [M];
    logic signed [ACW-1:0] r_acc;
    logic [KW-1:0]         r_k;
    logic [KW-1:0]         r_j;
    logic                  r_div0;
    logic                  r_rem;
    logic                  r_ovf;
    logic                  r_resid;

    logic                  w_wr_ok;
    logic [KW-1:0]         w_jlast;
    logic [KW-1:0]         w_aidx;
    logic                  w_avalid;
    logic signed [DW-1:0]  w_aval;
    logic signed [DW-1:0]  w_bval;
    logic signed [2*DW-1:0] w_prod;
    logic signed [ACW-1:0] w_acc_sub;
    logic signed [ACW-1:0] w_den;
    logic signed [ACW-1:0] w_quo;
    logic signed [ACW-1:0] w_rem;
    logic                  w_fits;
    logic signed [DW-1:0]  w_q;

    assign w_wr_ok = (r_state == S_IDLE) || (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (w_wr_ok && y_we && (int'(y_addr) < M + N - 1))
            r_y[y_addr] <= y_data;
        if (w_wr_ok && b_we && (int'(b_addr) < N))
            r_b[b_addr] <= b_data;
    end

    assign w_jlast  = (r_k < KW'(N - 1)) ? r_k : KW'(N - 1);
    assign w_aidx   = r_k - r_j;
    // Terms reaching below A[0] occur in the check phase and count as zero.
    assign w_avalid = (r_k >= r_j) && (w_aidx < KW'(M));
    assign w_aval   = w_avalid ? r_a[w_aidx[AW-1:0]] : '0;
    assign w_bval   = r_b[r_j[BAW-1:0]];
    assign w_prod   = w_aval * w_bval;
    assign w_acc_sub = r_acc - ACW'(w_prod);

    assign w_den  = (r_b[0] == '0) ? ACW'(1) : ACW'(r_b[0]);
    assign w_quo  = r_acc / w_den;
    assign w_rem  = r_acc % w_den;
    assign w_fits = (w_quo[ACW-1:DW-1] == {(ACW-DW+1){w_quo[DW-1]}});
    assign w_q    = w_fits ? w_quo[DW-1:0]
                  : (w_quo[ACW-1] ? {1'b1, {(DW-1){1'b0}}}
                                  : {1'b0, {(DW-1){1'b1}}});

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_INIT;
            S_INIT: begin
                if (r_div0)          w_next = S_DONE;
                else if (r_k == '0)  w_next = S_DIV;
                else                 w_next = S_MAC;
            end
            S_MAC:   if (r_j == w_jlast) w_next = S_DIV;
            S_DIV: begin
                if (r_k == KW'(M - 1))
                    w_next = (N == 1) ? S_DONE : S_CINIT;
                else
                    w_next = S_INIT;
            end
            S_CINIT: w_next = S_CMAC;
            S_CMAC:  if (r_j == KW'(N - 1)) w_next = S_CCMP;
            S_CCMP: begin
                if (r_k == KW'(M + N - 2)) w_next = S_DONE;
                else                       w_next = S_CINIT;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < M; i++) r_a[i] <= '0;
            r_acc   <= '0;
            r_k     <= '0;
            r_j     <= '0;
            r_div0  <= 1'b0;
            r_rem   <= 1'b0;
            r_ovf   <= 1'b0;
            r_resid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < M; i++) r_a[i] <= '0;
                        r_k     <= '0;
                        r_div0  <= (r_b[0] == '0);
                        r_rem   <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_resid <= 1'b0;
                    end
                end
                S_INIT: begin
                    r_acc <= ACW'(r_y[r_k[YAW-1:0]]);
                    r_j   <= KW'(1);
                end
                S_MAC, S_CMAC: begin
                    r_acc <= w_acc_sub;
                    r_j   <= r_j + KW'(1);
                end
                S_DIV: begin
                    r_a[r_k[AW-1:0]] <= w_q;
                    if (w_rem != '0) r_rem <= 1'b1;
                    if (!w_fits)     r_ovf <= 1'b1;
                    r_k <= r_k + KW'(1);
                end
                S_CINIT: begin
                    r_acc <= ACW'(r_y[r_k[YAW-1:0]]);
                    r_j   <= r_k - KW'(M) + KW'(1);
                end
                S_CCMP: begin
                    if (r_acc != '0) r_resid <= 1'b1;
                    r_k <= r_k + KW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done      = (r_state == S_DONE);
    assign a_data    = (int'(a_addr) < M) ? r_a[a_addr] : '0;
    assign err_div0  = r_div0;
    assign err_rem   = r_rem;
    assign err_ovf   = r_ovf;
    assign err_resid = r_resid;

endmodule

// File: tb/tb_deconvolution.sv
// Directed bench for deconvolution: a reference model pushes expected
// results at each start, popped and compared when the run completes.
module tb_deconvolution;

    localparam int M  = 6;
    localparam int N  = 8;
    localparam int DW = 16;
    localparam int YW = 36;

    logic        clk = 1'b0;
    logic        rst;
    logic        y_we;
    logic [3:0]  y_addr;
    logic [YW-1:0] y_data;
    logic        b_we;
    logic [2:0]  b_addr;
    logic [DW-1:0] b_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [2:0]  a_addr;
    logic [DW-1:0] a_data;
    logic        err_div0;
    logic        err_rem;
    logic        err_ovf;
    logic        err_resid;

    always #5 clk = ~clk;

    deconvolution #(.M(M), .N(N), .DW(DW), .YW(YW)) dut (
        .clk(clk), .rst(rst),
        .y_we(y_we), .y_addr(y_addr), .y_data(y_data),
        .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
        .start(start), .busy(busy), .done(done),
        .a_addr(a_addr), .a_data(a_data),
        .err_div0(err_div0), .err_rem(err_rem),
        .err_ovf(err_ovf), .err_resid(err_resid)
    );

    typedef struct packed {
        logic [M*DW-1:0] a;
        logic            div0;
        logic            rem;
        logic            ovf;
        logic            resid;
        logic [7:0]      lat;
    } exp_t;

    int     errors = 0;
    int     checks = 0;
    exp_t   sbq[$];
    longint my_y[M+N-1];
    longint my_b[N];
    longint a_ref[M] = '{143, 236, 767, -321, 231, 899};
    longint b_ref[N] = '{613, 218, -300, 824, -510, -323, -200, -200};

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t   e;
        longint ma[M];
        longint acc;
        longint q;
        e = '0;
        e.lat = 8'd69;
        for (int i = 0; i < M; i++) ma[i] = 0;
        if (my_b[0] == 0) begin
            e.div0 = 1'b1;
            e.lat  = 8'd1;
            return e;
        end
        for (int k = 0; k < M; k++) begin
            acc = my_y[k];
            for (int j = 1; j <= k && j < N; j++) acc -= ma[k-j] * my_b[j];
            q = acc / my_b[0];
            if (acc % my_b[0] != 0) e.rem = 1'b1;
            if (q > 32767) begin
                q = 32767; e.ovf = 1'b1;
            end else if (q < -32768) begin
                q = -32768; e.ovf = 1'b1;
            end
            ma[k] = q;
            e.a[k*DW +: DW] = q[DW-1:0];
        end
        for (int k = M; k <= M + N - 2; k++) begin
            acc = my_y[k];
            for (int j = k - M + 1; j < N; j++)
                if (k - j >= 0) acc -= ma[k-j] * my_b[j];
            if (acc != 0) e.resid = 1'b1;
        end
        return e;
    endfunction

    task automatic wr_y(input int i, input longint v);
        @(negedge clk);
        y_we = 1'b1; y_addr = i[3:0]; y_data = v[YW-1:0];
        @(posedge clk);
        #1 y_we = 1'b0;
    endtask

    task automatic wr_b(input int i, input longint v);
        @(negedge clk);
        b_we = 1'b1; b_addr = i[2:0]; b_data = v[DW-1:0];
        @(posedge clk);
        #1 b_we = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < N; i++) wr_b(i, my_b[i]);
        for (int i = 0; i < M + N - 1; i++) wr_y(i, my_y[i]);
    endtask

    task automatic launch(input bit track);
        if (track) sbq.push_back(model());
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int n0);
        int   n;
        exp_t e;
        n = n0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        e = sbq.pop_front();
        chk({tag, "_busy_cycles"}, n, e.lat);
        chk({tag, "_done"}, done, 1);
        for (int i = 0; i < M; i++) begin
            a_addr = i[2:0];
            #1;
            chk($sformatf("%s_a%0d", tag, i), $signed(a_data),
                $signed(e.a[i*DW +: DW]));
        end
        chk({tag, "_div0"}, err_div0, e.div0);
        chk({tag, "_rem"}, err_rem, e.rem);
        chk({tag, "_ovf"}, err_ovf, e.ovf);
        chk({tag, "_resid"}, err_resid, e.resid);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, done, 0);
    endtask

    initial begin
        rst = 1'b1; y_we = 1'b0; y_addr = '0; y_data = '0;
        b_we = 1'b0; b_addr = '0; b_data = '0; start = 1'b0; a_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div0", err_div0, 0);
        chk("rst_rem", err_rem, 0);
        chk("rst_ovf", err_ovf, 0);
        chk("rst_resid", err_resid, 0);
        chk("rst_a0", a_data, 0);
        rst = 1'b0;

        for (int i = 0; i < N; i++) my_b[i] = b_ref[i];
        for (int i = 0; i < M + N - 1; i++) my_y[i] = 0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) my_y[i+j] += a_ref[i] * b_ref[j];
        load_all();
        launch(1);
        finish_run("t1", 0);
        for (int i = 0; i < M; i++) begin
            a_addr = i[2:0];
            #1 chk($sformatf("t1_ref_a%0d", i), $signed(a_data), a_ref[i]);
        end
        a_addr = 3'd6;
        #1 chk("oob_a6", a_data, 0);
        a_addr = 3'd7;
        #1 chk("oob_a7", a_data, 0);

        my_y[12] += 1;
        wr_y(12, my_y[12]);
        launch(1);
        finish_run("t2", 0);

        my_y[12] -= 1;
        wr_y(12, my_y[12]);
        my_y[0] = 87660;
        wr_y(0, my_y[0]);
        launch(1);
        finish_run("t3", 0);
        a_addr = 3'd0;
        #1 chk("t3_a0_143", $signed(a_data), 143);

        my_b[0] = 0;
        wr_b(0, 0);
        launch(1);
        finish_run("t4", 0);

        my_b[0] = 613;
        wr_b(0, 613);
        my_y[0] = 87659;
        wr_y(0, my_y[0]);
        launch(0);
        repeat (29) @(negedge clk);
        chk("t5_busy_c30", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_done", done, 0);
        chk("t5_abort_resid", err_resid, 0);
        for (int i = 0; i < M; i++) begin
            a_addr = i[2:0];
            #1 chk($sformatf("t5_clr_a%0d", i), a_data, 0);
        end
        rst = 1'b0;
        launch(1);
        y_we = 1'b1; y_addr = 4'd0; y_data = 36'd5;
        b_we = 1'b1; b_addr = 3'd0; b_data = 16'd7;
        start = 1'b1;
        @(negedge clk);
        y_we = 1'b0; b_we = 1'b0; start = 1'b0;
        finish_run("t5", 1);

        for (int i = 0; i < N; i++) my_b[i] = (i == 0) ? 1 : 0;
        for (int i = 0; i < M + N - 1; i++) my_y[i] = (i == 0) ? 100000 : 0;
        load_all();
        launch(1);
        finish_run("t6", 0);
        a_addr = 3'd0;
        #1 chk("t6_clamp", $signed(a_data), 32767);

        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
